// File: rtl/rename_commit_queue_pkg.sv
// rename_commit_queue_pkg
//   Shared types and default sizing for the rename commit queue.
//   RCQ_DEPTH / RCQ_ARCH_W / RCQ_PHYS_W are the default configuration.
//   rcq_entry_t is the per-entry record at the default register widths.
package rename_commit_queue_pkg;

  localparam int RCQ_DEPTH  = 8;
  localparam int RCQ_ARCH_W = 5;
  localparam int RCQ_PHYS_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_rd;
    logic [RCQ_PHYS_W-1:0] prd;
    logic [RCQ_ARCH_W-1:0] ard;
  } rcq_entry_t;

endpackage

// File: rtl/rename_commit_queue.sv
// rename_commit_queue
//   In-order retirement tracker placed after the renaming map. Renamed
//   instructions are recorded in a circular buffer at the tail. Writebacks
//   mark entries done by tag, in any order. The head entry retires once it
//   is done, one per cycle. Retirement releases its physical rd through
//   we_gp_o / waddr_o.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   alloc_*              allocation request; alloc_ready_o = not full,
//                        alloc_tag_o = tag given to this allocation (tail)
//   wb_valid_i/wb_tag_i  out-of-order completion by tag
//   flush_i              discard every entry (highest priority)
//   we_gp_o/waddr_o      registered release strobe and physical rd
//   commit_ard_o         architectural rd of the retiring entry (trace)
//   count_o              occupied entries
//   wb_err_o             sticky: a writeback hit an invalid entry
//
// Build option
//   RENAME_CQ_WB_BYPASS_EN: when defined, a writeback to the head entry
//   retires it on the same edge. This saves one cycle of release latency.
module rename_commit_queue
  import rename_commit_queue_pkg::*;
#(
  parameter int ARCH_REG_WIDTH = RCQ_ARCH_W,
  parameter int PHYS_REG_WIDTH = RCQ_PHYS_W,
  parameter int DEPTH          = RCQ_DEPTH,
  parameter int TAG_WIDTH      = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      alloc_valid_i,
  input  logic                      alloc_has_rd_i,
  input  logic [PHYS_REG_WIDTH-1:0] alloc_prd_i,
  input  logic [ARCH_REG_WIDTH-1:0] alloc_ard_i,
  output logic                      alloc_ready_o,
  output logic [TAG_WIDTH-1:0]      alloc_tag_o,
  input  logic                      wb_valid_i,
  input  logic [TAG_WIDTH-1:0]      wb_tag_i,
  input  logic                      flush_i,
  output logic                      we_gp_o,
  output logic [PHYS_REG_WIDTH-1:0] waddr_o,
  output logic [ARCH_REG_WIDTH-1:0] commit_ard_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      wb_err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Same shape as rcq_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      has_rd;
    logic [PHYS_REG_WIDTH-1:0] prd;
    logic [ARCH_REG_WIDTH-1:0] ard;
  } entry_t;

  entry_t                    r_entries [DEPTH];
  logic [TAG_WIDTH-1:0]      r_head;
  logic [TAG_WIDTH-1:0]      r_tail;
  logic [CNT_W-1:0]          r_count;
  logic                      r_we_gp;
  logic [PHYS_REG_WIDTH-1:0] r_waddr;
  logic [ARCH_REG_WIDTH-1:0] r_commit_ard;
  logic                      r_wb_err;

  logic w_alloc_ready;
  logic w_alloc_fire;
  logic w_wb_hit;
  logic w_wb_bad;
  logic w_head_done;
  logic w_retire;

  // Ready depends only on the pre-edge count. A retire in the same cycle
  // does not open a slot until the next cycle.
  assign w_alloc_ready = (r_count != CNT_W'(DEPTH));
  assign w_alloc_fire  = alloc_valid_i && w_alloc_ready;
  assign w_wb_hit      = wb_valid_i && r_entries[wb_tag_i].valid;
  // A bad writeback during a flush is discarded together with the flush.
  assign w_wb_bad      = wb_valid_i && !r_entries[wb_tag_i].valid && !flush_i;

`ifdef RENAME_CQ_WB_BYPASS_EN
  assign w_head_done = r_entries[r_head].done ||
                       (wb_valid_i && (wb_tag_i == r_head) && r_entries[r_head].valid);
`else
  assign w_head_done = r_entries[r_head].done;
`endif

  assign w_retire = r_entries[r_head].valid && w_head_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_we_gp      <= 1'b0;
      r_waddr      <= '0;
      r_commit_ard <= '0;
      r_wb_err     <= 1'b0;
    end else begin
      if (w_wb_bad) begin
        r_wb_err <= 1'b1;
      end
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_entries[i].valid <= 1'b0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_we_gp <= 1'b0;
      end else begin
        if (w_wb_hit) begin
          r_entries[wb_tag_i].done <= 1'b1;
        end
        // The tail slot is never the head of a valid entry while allocation is
        // allowed. It is also never a writeback target, because the tail entry
        // is invalid. So these writes cannot collide.
        if (w_alloc_fire) begin
          r_entries[r_tail].valid  <= 1'b1;
          r_entries[r_tail].done   <= 1'b0;
          r_entries[r_tail].has_rd <= alloc_has_rd_i;
          r_entries[r_tail].prd    <= alloc_prd_i;
          r_entries[r_tail].ard    <= alloc_ard_i;
          r_tail                   <= r_tail + TAG_WIDTH'(1);
        end
        if (w_retire) begin
          r_entries[r_head].valid <= 1'b0;
          r_head                  <= r_head + TAG_WIDTH'(1);
          r_we_gp                 <= r_entries[r_head].has_rd;
          r_waddr                 <= r_entries[r_head].prd;
          r_commit_ard            <= r_entries[r_head].ard;
        end else begin
          r_we_gp <= 1'b0;
        end
        case ({w_alloc_fire, w_retire})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign alloc_ready_o = w_alloc_ready;
  assign alloc_tag_o   = r_tail;
  assign count_o       = r_count;
  assign we_gp_o       = r_we_gp;
  assign waddr_o       = r_waddr;
  assign commit_ard_o  = r_commit_ard;
  assign wb_err_o      = r_wb_err;

endmodule

// File: tb/tb_rename_commit_queue.sv
// Testbench for rename_commit_queue. A program-order queue model predicts
// every output each cycle. Directed scenarios add literal expectations.
module tb_rename_commit_queue;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int DEPTH = 8;
  localparam int TW = 3;
`ifdef RENAME_CQ_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  // Cycles between the cycle a head writeback is driven and the check
  // that first sees its release pulse.
  localparam int LAT = BYPASS ? 0 : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_has_rd = 1'b0;
  logic [PW-1:0] alloc_prd = '0;
  logic [AW-1:0] alloc_ard = '0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          wb_valid = 1'b0;
  logic [TW-1:0] wb_tag = '0;
  logic          flush = 1'b0;
  logic          we_gp;
  logic [PW-1:0] waddr;
  logic [AW-1:0] commit_ard;
  logic [TW:0]   count;
  logic          wb_err;

  rename_commit_queue #(
    .ARCH_REG_WIDTH(AW), .PHYS_REG_WIDTH(PW), .DEPTH(DEPTH), .TAG_WIDTH(TW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_has_rd_i(alloc_has_rd),
    .alloc_prd_i(alloc_prd), .alloc_ard_i(alloc_ard),
    .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .flush_i(flush),
    .we_gp_o(we_gp), .waddr_o(waddr), .commit_ard_o(commit_ard),
    .count_o(count), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int tag; bit has_rd; int prd; int ard; bit done;
  } ment_t;
  ment_t mq[$];
  int m_tail, m_waddr, m_ard;
  bit m_we, m_err;

  typedef struct { int cyc; int waddr; } cap_t;
  cap_t cap[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_we = 0; m_waddr = 0; m_ard = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit ret;
    int idx;
    ment_t e;
    if (flush) begin
      mq.delete(); m_tail = 0; m_we = 0;
      return;
    end
    ret = 0;
    if (mq.size() > 0)
      ret = mq[0].done || (BYPASS && wb_valid && (int'(wb_tag) == mq[0].tag));
    if (wb_valid) begin
      idx = -1;
      foreach (mq[i]) if (mq[i].tag == int'(wb_tag)) idx = i;
      if (idx < 0) m_err = 1; else mq[idx].done = 1;
    end
    if (alloc_valid && mq.size() < DEPTH) begin
      e.tag = m_tail; e.has_rd = alloc_has_rd; e.prd = alloc_prd;
      e.ard = alloc_ard; e.done = 0;
      mq.push_back(e);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (ret) begin
      e = mq.pop_front();
      m_we = e.has_rd; m_waddr = e.prd; m_ard = e.ard;
    end else begin
      m_we = 0;
    end
  endtask

  task automatic check_all();
    chk("alloc_ready", alloc_ready, (mq.size() != DEPTH));
    chk("alloc_tag", alloc_tag, m_tail);
    chk("count", count, mq.size());
    chk("we_gp", we_gp, m_we);
    chk("waddr", waddr, m_waddr);
    chk("commit_ard", commit_ard, m_ard);
    chk("wb_err", wb_err, m_err);
    if (we_gp === 1'b1) begin
      cap_t c; c.cyc = cyc; c.waddr = waddr; cap.push_back(c);
    end
  endtask

  // One clock: the DUT and the model consume the inputs at posedge. Outputs
  // are checked at the following negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    $display("cyc %0d av=%0b prd=%0d wb=%0b/%0d fl=%0b | tag=%0d cnt=%0d we=%0b wa=%0d err=%0b",
             cyc, alloc_valid, alloc_prd, wb_valid, wb_tag, flush,
             alloc_tag, count, we_gp, waddr, wb_err);
    check_all();
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_has_rd = 0; alloc_prd = '0; alloc_ard = '0;
    wb_valid = 0; wb_tag = '0; flush = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    cap.delete();
    check_all();
  endtask

  task automatic alloc(int prd, int ard, bit has_rd);
    idle_inputs();
    alloc_valid = 1; alloc_prd = PW'(prd); alloc_ard = AW'(ard); alloc_has_rd = has_rd;
    cycle();
    idle_inputs();
  endtask

  task automatic wb(int tag);
    idle_inputs();
    wb_valid = 1; wb_tag = TW'(tag);
    cycle();
    idle_inputs();
  endtask

  task automatic idle(int n);
    idle_inputs();
    repeat (n) cycle();
  endtask

  int t0;
  int exp_seq[$];

  initial begin
    // ---- reset, then idle ----
    do_reset();
    idle(2);
    chk("rst_count", count, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_we", we_gp, 0);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_waddr", waddr, 0);

    // ---- in-order completion ----
    alloc(32, 1, 1); alloc(33, 2, 1); alloc(34, 3, 1);
    chk("io_count3", count, 3);
    wb(0); t0 = cyc; wb(1); wb(2);
    idle(3);
    chk("io_npulse", cap.size(), 3);
    if (cap.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("io_waddr", cap[i].waddr, 32 + i);
        chk("io_cyc", cap[i].cyc, t0 + LAT + i);
      end
    end
    chk("io_count0", count, 0);

    // ---- out-of-order completion ----
    do_reset();
    alloc(40, 4, 1); alloc(41, 5, 1);
    wb(1); idle(2);
    chk("ooo_nopulse", cap.size(), 0);
    wb(0); t0 = cyc;
    idle(3);
    chk("ooo_npulse", cap.size(), 2);
    if (cap.size() == 2) begin
      chk("ooo_first", cap[0].waddr, 40);
      chk("ooo_second", cap[1].waddr, 41);
      chk("ooo_cyc0", cap[0].cyc, t0 + LAT);
      chk("ooo_cyc1", cap[1].cyc, t0 + LAT + 1);
    end

    // ---- full and wrap ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(10 + i, i + 1, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_count", count, 8);
    alloc(99, 9, 1);
    chk("full_9th_count", count, 8);
    chk("full_9th_tag", alloc_tag, 0);
    wb(0); wb(1); idle(3);
    chk("wrap_count6", count, 6);
    chk("wrap_tag0", alloc_tag, 0);
    alloc(20, 20, 1);
    chk("wrap_tag1", alloc_tag, 1);
    alloc(21, 21, 1);
    chk("wrap_count8", count, 8);
    wb(1); wb(0);
    for (int t = 7; t >= 2; t--) wb(t);
    idle(12);
    exp_seq = '{10, 11, 12, 13, 14, 15, 16, 17, 20, 21};
    chk("wrap_npulse", cap.size(), exp_seq.size());
    if (cap.size() == exp_seq.size())
      foreach (exp_seq[i]) chk("wrap_order", cap[i].waddr, exp_seq[i]);
    chk("wrap_count0", count, 0);

    // ---- no-destination entry and bad writeback ----
    do_reset();
    alloc(50, 7, 0);
    wb(0); idle(3);
    chk("nodest_nopulse", cap.size(), 0);
    chk("nodest_count", count, 0);
    chk("nodest_err", wb_err, 0);
    wb(5);
    chk("badwb_err", wb_err, 1);
    idle(3);
    chk("badwb_sticky", wb_err, 1);

    // ---- flush ----
    do_reset();
    alloc(60, 1, 1); alloc(61, 2, 1); alloc(62, 3, 1); alloc(63, 4, 1);
    wb(1); wb(2);
    chk("fl_count4", count, 4);
    idle_inputs(); flush = 1; cycle(); idle_inputs();
    chk("fl_count0", count, 0);
    chk("fl_we", we_gp, 0);
    idle(4);
    chk("fl_nopulse", cap.size(), 0);
    chk("fl_tag", alloc_tag, 0);

    // ---- randomized traffic ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 63) == 0) begin
        flush = 1;
      end else begin
        alloc_valid  = ($urandom_range(0, 99) < 55);
        alloc_has_rd = $urandom_range(0, 3) != 0;
        alloc_prd    = PW'($urandom);
        alloc_ard    = AW'($urandom_range(1, 31));
        if ($urandom_range(0, 99) < 60) begin
          wb_valid = 1;
          if (mq.size() > 0 && $urandom_range(0, 15) != 0)
            wb_tag = TW'(mq[$urandom_range(0, mq.size() - 1)].tag);
          else
            wb_tag = TW'($urandom);
        end
      end
      cycle();
    end
    idle_inputs();

    // ---- asynchronous reset during a release pulse ----
    do_reset();
    alloc(45, 6, 1);
    wb(0);
    for (int k = 0; k < 4 && we_gp !== 1'b1; k++) cycle();
    chk("arst_pulse_seen", we_gp, 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst_we", we_gp, 0);
    chk("arst_count", count, 0);
    chk("arst_waddr", waddr, 0);
    chk("arst_ready", alloc_ready, 1);
    #1 rst_n = 1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
